seq_round_engine: RTL

- Parametrised round controller for the digit-memory game.
- Plays back a stored digit sequence of selectable length from the sequence RAM to the random-number display, one digit per dwell period.
- Then collects and checks the player's digits one at a time, with a per-digit entry timeout.
- Sits between the sequencer/RAM read port, the 7-segment digit decoder, the tick generator and the per-player score/win logic; generalises the fixed-length show/check path of the current game controller.

---
 rtl/seq_round_engine.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/seq_round_engine.sv
// Round controller for the digit-memory game: plays a stored digit sequence out of
// the sequence RAM, then collects the player's digits and checks them one at a time.
module seq_round_engine #(
  parameter int DIGIT_W     = 4,
  parameter int ADDR_W      = 5,
  parameter int DWELL_TICKS = 20,
  parameter int GAP_TICKS   = 2,
  parameter int ENTRY_TICKS = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W:0]    seq_len,
  input  logic               tick,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [DIGIT_W-1:0] ram_data,
  input  logic [DIGIT_W-1:0] user_digit,
  input  logic               user_strobe,
  output logic [DIGIT_W-1:0] disp_digit,
  output logic               disp_valid,
  output logic               busy,
  output logic               entry_phase,
  output logic [ADDR_W:0]    score,
  output logic               round_win,
  output logic               round_lose,
  output logic               timeout_flag
);

  localparam int MAX_A = (DWELL_TICKS > GAP_TICKS) ? DWELL_TICKS : GAP_TICKS;
  localparam int MAX_T = (MAX_A > ENTRY_TICKS) ? MAX_A : ENTRY_TICKS;
  localparam int CNT_W = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_TICKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0]  ENTRY_LAST = CNT_W'(ENTRY_TICKS - 1);
  localparam logic [ADDR_W:0]   MAX_LEN    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_LEN    = (ADDR_W+1)'(1);

  typedef enum logic [3:0] {
    IDLE, S_FETCH, S_WAIT, SHOW, GAP, C_FETCH, C_WAIT, ENTRY, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [ADDR_W:0]      len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]      score_q, score_d;
  logic                 timeout_q, timeout_d;
  logic [DIGIT_W-1:0]   disp_digit_q, disp_digit_d;
  logic                 disp_valid_q, disp_valid_d;
  logic [DIGIT_W-1:0]   expected_q, expected_d;
  logic                 win_q, win_d;
  logic                 lose_q, lose_d;
  logic                 busy_q, busy_d;
  logic                 entry_q, entry_d;
  logic                 last_digit;

  assign last_digit = ({1'b0, idx_q} == (len_q - ONE_LEN));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    score_d      = score_q;
    timeout_d    = timeout_q;
    disp_digit_d = disp_digit_q;
    disp_valid_d = disp_valid_q;
    expected_d   = expected_q;
    win_d        = 1'b0;
    lose_d       = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d      = IDLE;
      disp_valid_d = 1'b0;
      idx_d        = '0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (seq_len == '0)          len_d = ONE_LEN;
            else if (seq_len > MAX_LEN) len_d = MAX_LEN;
            else                        len_d = seq_len;
            idx_d     = '0;
            score_d   = '0;
            timeout_d = 1'b0;
            cnt_d     = '0;
            state_d   = S_FETCH;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          disp_digit_d = ram_data;
          disp_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = SHOW;
        end
        SHOW: begin
          if (tick) begin
            if (cnt_q == DWELL_LAST) begin
              disp_valid_d = 1'b0;
              cnt_d        = '0;
              if (last_digit) begin
                idx_d   = '0;
                state_d = C_FETCH;
              end else begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = (GAP_TICKS == 0) ? S_FETCH : GAP;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (cnt_q == GAP_LAST) begin
              cnt_d   = '0;
              state_d = S_FETCH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        C_FETCH: state_d = C_WAIT;
        C_WAIT: begin
          expected_d = ram_data;
          cnt_d      = '0;
          state_d    = ENTRY;
        end
        ENTRY: begin
          // A strobe wins over an expiring tick in the same cycle.
          if (user_strobe) begin
            if (user_digit == expected_q) begin
              score_d = score_q + ONE_LEN;
              cnt_d   = '0;
              if (last_digit) begin
                win_d   = 1'b1;
                state_d = DONE;
              end else begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = C_FETCH;
              end
            end else begin
              lose_d  = 1'b1;
              state_d = DONE;
            end
          end else if (tick) begin
            if (cnt_q == ENTRY_LAST) begin
              lose_d    = 1'b1;
              timeout_d = 1'b1;
              state_d   = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d  = (state_d != IDLE);
    entry_d = (state_d == C_FETCH) || (state_d == C_WAIT) || (state_d == ENTRY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      score_q      <= '0;
      timeout_q    <= 1'b0;
      disp_digit_q <= '0;
      disp_valid_q <= 1'b0;
      expected_q   <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      busy_q       <= 1'b0;
      entry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      score_q      <= score_d;
      timeout_q    <= timeout_d;
      disp_digit_q <= disp_digit_d;
      disp_valid_q <= disp_valid_d;
      expected_q   <= expected_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      busy_q       <= busy_d;
      entry_q      <= entry_d;
    end
  end

  assign ram_addr     = idx_q;
  assign disp_digit   = disp_digit_q;
  assign disp_valid   = disp_valid_q;
  assign busy         = busy_q;
  assign entry_phase  = entry_q;
  assign score        = score_q;
  assign round_win    = win_q;
  assign round_lose   = lose_q;
  assign timeout_flag = timeout_q;

endmodule
